shift_pipe: RTL and testbench
=============================

# shift_pipe

Two-stage pipelined shift/rotate unit of the optimized ALU. Accepts RV32 shift and rotate operations over a valid/ready handshake. Stage 1 reduces every operation to a right funnel operation: it forms the high word, low word and amount. Stage 2 evaluates the funnel window and holds the registered result for the writeback consumer.

## Interface
- N, 5: log2 of datapath width; XLEN = 2**N.
- TAG_W, 5: width of the pass-through tag (destination register index).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready at an edge.
- in_op  in  3  operation: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101–111 illegal.
- in_a  in  XLEN  operand to shift.
- in_b  in  XLEN  shift amount source; only in_b[N-1:0] is used.
- in_tag  in  TAG_W  passed unchanged to out_tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready at an edge.
- out_result  out  XLEN  shifted/rotated value.
- out_tag  out  TAG_W  tag of the result.
- out_illegal  out  1  set when the op was 101–111.

## Operation
- s = in_b[N-1:0]. Stage 1 registers hi, lo, amt, bypass, illegal, a, tag and s1_valid:
  - SRL: hi=0, lo=a, amt=s.
  - SRA: hi = XLEN copies of a[XLEN-1], lo=a, amt=s.
  - ROR: hi=a, lo=a, amt=s.
  - SLL: hi=a, lo=0, amt=(2**N − s) mod 2**N.
  - ROL: hi=a, lo=a, amt=(2**N − s) mod 2**N.
  - Illegal op: hi=lo=0, amt=0, illegal=1.
- bypass = (s==0) and the op is legal.
- Stage 2 computes the result and registers it with s2_valid, tag and illegal:
  - If bypass, result = a.
  - Otherwise, result = ({hi,lo} >> amt)[XLEN-1:0].
  - Only amt in 1..XLEN−1 is exercised when bypass is clear; for SLL/ROL this amount is XLEN − s, which never needs a window starting at bit XLEN.
- Illegal ops flow through both stages: result 0, out_illegal=1, never dropped.
- out_result, out_tag and out_illegal are driven directly from stage-2 registers.

## Timing
- Reset: s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_tag=0, out_illegal=0. in_ready=0 while rst=1 and 1 in the first cycle after.
- Advance conditions:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv && !flush && !rst.
- Latency: request accepted at edge k → out_valid=1 after edge k+1 (result at output during cycle k+1..k+2) if stage 2 is free.
  - Restated: two register stages, result visible the cycle after stage 1 captures.
- Throughput: one op per cycle with out_ready held high.
- Backpressure:
  - While out_valid && !out_ready, out_result, out_tag and out_illegal hold stable.
  - Stage 1 holds if it is valid.
  - At most 2 ops in flight; in_ready drops only when both stages are full and out_ready=0.
- Simultaneous handshake: an output transfer and an input accept in the same edge both occur; no bubble is inserted.
- Flush:
  - At the edge where flush=1, s1_valid and s2_valid clear.
  - An in_valid in that cycle is not accepted; in_ready=0.
  - An out_valid && out_ready transfer in the flush cycle still counts as delivered.
  - Data registers need not clear.
- Reset mid-operation: same as flush, plus outputs return to the reset values above.
- Stage registers load only on their advance condition. Data is never lost or duplicated under any out_ready pattern.

## Test plan
- Reset then single op with out_ready=1:
  - Stimulus: SLL a=0x0000_0001, b=31.
  - Required: out_result=0x8000_0000, out_valid one cycle after stage-1 capture.
- Arithmetic/rotate set, back-to-back, one op per cycle:
  - SRA a=0x8000_0000 s=4 → 0xF800_0000.
  - SRL a=0x8000_0000 s=4 → 0x0800_0000.
  - ROL a=0x1234_5678 s=8 → 0x3456_7812.
  - ROR same → 0x7812_3456.
- Boundary amounts:
  - All five ops with s=0, a=0xDEAD_BEEF → 0xDEAD_BEEF.
  - in_b=0xFFFF_FFE1 uses s=1: SLL → 0xBD5B_7DDE.
- Illegal op 110 with a=0xFFFF_FFFF → out_result=0, out_illegal=1, tag preserved.
- Backpressure:
  - Stimulus: hold out_ready=0 with 3 requests offered.
  - Required: exactly 2 accepted, in_ready=0 and output stable.
  - Then release out_ready: all 3 results emerge in order, tags intact.
- Flush with both stages full and in_valid=1 → next cycle out_valid=0, nothing accepted in that cycle. The following request completes normally.

Source files
------------

// File: rtl/shift_pipe.sv
// shift_pipe: two-stage RV32 shift/rotate unit reducing every op to a right funnel shift.
module shift_pipe #(
  parameter int N = 5,
  parameter int TAG_W = 5,
  localparam int XLEN = 2**N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  logic             s1_valid, s1_bypass, s1_illegal, s2_valid;
  logic [XLEN-1:0]  s1_hi, s1_lo, s1_a;
  logic [N-1:0]     s1_amt;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_adv, s2_adv, acc, illegal, left;
  logic [N-1:0]     s;
  logic [XLEN-1:0]  hi, lo, result;
  logic [N-1:0]     amt;
  logic [2*XLEN-1:0] win;
  logic             unused;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv && !flush && !rst;
  assign acc       = in_valid && in_ready;
  assign out_valid = s2_valid;
  assign s         = in_b[N-1:0];
  assign illegal   = in_op > 3'd4;
  assign left      = in_op == 3'd0 || in_op == 3'd3;
  assign unused    = ^{in_b[XLEN-1:N], win[2*XLEN-1:XLEN]};

  // left ops become a right funnel by XLEN-s; s==0 is bypassed so amt never wraps to a full word
  always_comb begin
    hi = (illegal || in_op == 3'd1) ? '0 : in_op == 3'd2 ? {XLEN{in_a[XLEN-1]}} : in_a;
    lo = (illegal || in_op == 3'd0) ? '0 : in_a;
    amt = illegal ? '0 : left ? -s : s;
  end

  assign win    = {s1_hi, s1_lo} >> s1_amt;
  assign result = s1_bypass ? s1_a : win[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (acc) begin
      s1_hi      <= hi;
      s1_lo      <= lo;
      s1_amt     <= amt;
      s1_bypass  <= !illegal && s == '0;
      s1_illegal <= illegal;
      s1_a       <= in_a;
      s1_tag     <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else begin
      s1_valid <= flush ? 1'b0 : s1_adv ? acc : s1_valid;
      s2_valid <= flush ? 1'b0 : s2_adv ? s1_valid : s2_valid;
      if (s2_adv && s1_valid) begin
        out_result  <= result;
        out_tag     <= s1_tag;
        out_illegal <= s1_illegal;
      end
    end
  end
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: table vectors, hand sequences and random traffic against a scoreboard model.
module tb_shift_pipe;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] r;
    logic        ill;
  } vec_t;

  logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic        in_ready, out_valid, out_illegal;
  logic [2:0]  in_op = 0;
  logic [31:0] in_a = 0, in_b = 0, out_result;
  logic [4:0]  in_tag = 0, out_tag;

  vec_t pend[$];
  vec_t q[$];
  vec_t tbl[12];
  int   pass = 0, total = 0, acc_cnt = 0;
  logic held = 0;
  logic [37:0] prev_out;

  shift_pipe dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int s = int'(b % 32);
    case (op)
      3'd0: return a << s;
      3'd1: return a >> s;
      3'd2: return 32'($signed(a) >>> s);
      3'd3: return (a << s) | (a >> (32 - s));
      3'd4: return (a >> s) | (a << (32 - s));
      default: return 32'h0;
    endcase
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    return '{op: op, a: a, b: b, tag: tag, r: model(op, a, b), ill: op > 3'd4};
  endfunction

  task automatic tick();
    logic acc, del;
    in_valid = pend.size() > 0;
    if (in_valid) begin
      in_op = pend[0].op; in_a = pend[0].a; in_b = pend[0].b; in_tag = pend[0].tag;
    end
    @(negedge clk);
    acc = in_valid && in_ready;
    del = out_valid && out_ready;
    if (held) chk("hold stable", {out_valid, out_result, out_tag}, prev_out);
    if (out_valid) begin
      if (q.size() == 0) chk("spurious out_valid", 1, 0);
      else chk($sformatf("result tag%0d", q[0].tag), {out_result, out_tag, out_illegal},
               {q[0].r, q[0].tag, q[0].ill});
    end
    held = out_valid && !out_ready && !flush && !rst;
    prev_out = {out_valid, out_result, out_tag};
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (del) void'(q.pop_front());
      if (flush) q.delete();
      if (acc) begin
        q.push_back(pend[0]);
        void'(pend.pop_front());
        acc_cnt++;
      end
    end
    #1;
  endtask

  task automatic drain(output int cycles);
    cycles = 0;
    while ((q.size() > 0 || pend.size() > 0) && cycles < 300) begin
      tick();
      cycles++;
    end
    chk("drain", q.size() + pend.size(), 0);
  endtask

  initial begin
    int cyc;
    tbl[0]  = '{3'd0, 32'h0000_0001, 32'd31, 5'd1, 32'h8000_0000, 1'b0};
    tbl[1]  = '{3'd2, 32'h8000_0000, 32'd4, 5'd2, 32'hF800_0000, 1'b0};
    tbl[2]  = '{3'd1, 32'h8000_0000, 32'd4, 5'd3, 32'h0800_0000, 1'b0};
    tbl[3]  = '{3'd3, 32'h1234_5678, 32'd8, 5'd4, 32'h3456_7812, 1'b0};
    tbl[4]  = '{3'd4, 32'h1234_5678, 32'd8, 5'd5, 32'h7812_3456, 1'b0};
    tbl[5]  = '{3'd0, 32'hDEAD_BEEF, 32'd0, 5'd6, 32'hDEAD_BEEF, 1'b0};
    tbl[6]  = '{3'd1, 32'hDEAD_BEEF, 32'd0, 5'd7, 32'hDEAD_BEEF, 1'b0};
    tbl[7]  = '{3'd2, 32'hDEAD_BEEF, 32'd0, 5'd8, 32'hDEAD_BEEF, 1'b0};
    tbl[8]  = '{3'd3, 32'hDEAD_BEEF, 32'd0, 5'd9, 32'hDEAD_BEEF, 1'b0};
    tbl[9]  = '{3'd4, 32'hDEAD_BEEF, 32'd0, 5'd10, 32'hDEAD_BEEF, 1'b0};
    tbl[10] = '{3'd0, 32'hDEAD_BEEF, 32'hFFFF_FFE1, 5'd11, 32'hBD5B_7DDE, 1'b0};
    tbl[11] = '{3'd6, 32'hFFFF_FFFF, 32'd3, 5'd27, 32'h0, 1'b1};

    tick();
    tick();
    chk("reset in_ready", in_ready, 0);
    chk("reset outputs", {out_valid, out_result, out_tag, out_illegal}, 0);
    rst = 0;
    #1;
    chk("in_ready after reset", in_ready, 1);

    pend.push_back(tbl[0]);
    tick();
    chk("s1 only, out_valid", out_valid, 0);
    tick();
    chk("latency out_valid", out_valid, 1);
    drain(cyc);

    foreach (tbl[i]) pend.push_back(tbl[i]);
    drain(cyc);
    chk("back-to-back cycles", cyc, 14);

    out_ready = 0;
    acc_cnt = 0;
    pend.push_back(mk(3'd1, 32'hF0F0_1234, 32'd3, 5'd21));
    pend.push_back(mk(3'd3, 32'h0BAD_F00D, 32'd13, 5'd22));
    pend.push_back(mk(3'd2, 32'h9000_0001, 32'd31, 5'd23));
    repeat (5) tick();
    chk("backpressure accepts", acc_cnt, 2);
    chk("backpressure in_ready", in_ready, 0);
    out_ready = 1;
    drain(cyc);
    chk("backpressure total", acc_cnt, 3);

    out_ready = 0;
    acc_cnt = 0;
    pend.push_back(mk(3'd0, 32'h0000_00FF, 32'd4, 5'd12));
    pend.push_back(mk(3'd4, 32'hCAFE_0001, 32'd1, 5'd13));
    pend.push_back(mk(3'd2, 32'h7FFF_0000, 32'd16, 5'd14));
    repeat (3) tick();
    flush = 1;
    tick();
    flush = 0;
    chk("flush accepts", acc_cnt, 2);
    chk("flush out_valid", out_valid, 0);
    out_ready = 1;
    drain(cyc);
    chk("post-flush accepts", acc_cnt, 3);

    for (int i = 0; i < 600; i++) begin
      if (pend.size() < 2 && $urandom_range(0, 3) != 0)
        pend.push_back(mk(3'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom)));
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 29) == 0;
      tick();
    end
    flush = 0;
    out_ready = 1;
    drain(cyc);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
